mem_arbiter: RTL

Single-core memory arbiter between the instruction cache, the data cache and the single-ported RAM. It accepts word requests from `icache` and `dcache` on the `caches_if` signals and grants exactly one requester the RAM per transaction, holding the grant until RAM reports `ACCESS`. It then returns `ramload` and drops the granted cache's wait. Data has priority; a streak limiter keeps the instruction side from starving during long dcache write-back/fill/flush bursts.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 73 +++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-state and arbiter-state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to icache or dcache, data first with an anti-starvation streak limit
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);
  localparam logic [3:0] SMAX = 4'(DSTREAK_MAX);
  arb_state_t state_q, state_d;
  logic [3:0] dstreak_q, dstreak_d;
  logic dreq, acc, ddone, idone;
  assign dreq  = dREN | dWEN;
  assign acc   = ramstate == ACCESS;
  assign ddone = state_q == DGRANT && dreq && acc;
  assign idone = state_q == IGRANT && iREN && acc;
  assign iload = ramload;
  assign dload = ramload;
  // The streak only matters while the icache is actually waiting.
  assign dstreak_d = (!iREN || idone) ? 4'd0 : (ddone && dstreak_q != SMAX) ? dstreak_q + 4'd1 : dstreak_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IDLE:   state_d = (iREN && dstreak_q == SMAX) ? IGRANT : dreq ? DGRANT : iREN ? IGRANT : IDLE;
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~ddone;
        state_d  = (dreq && !acc) ? DGRANT : IDLE;
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = ~idone;
        state_d = (iREN && !acc) ? IGRANT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
